// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store stage: FSM encoding,
// RISC-V funct3 width codes and byte-strobe patterns.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store stage: store strobes and data shift,
// load extraction with sign/zero extension, and the misalignment flag.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] r;

  assign r     = rdata >> {off, 3'b000};
  assign wdata = store_data << {off, 3'b000};

  // Upper strobes of an offset halfword simply fall off the 4-bit mask.
  always_comb begin
    wmask = MASK_W;
    case (funct3)
      SB:      wmask = MASK_B << off;
      SH:      wmask = MASK_H << off;
      SW:      wmask = MASK_W;
      default: wmask = MASK_W;
    endcase
  end

  always_comb begin
    load_data = r;
    case (funct3)
      LB:      load_data = {{24{r[7]}}, r[7:0]};
      LBU:     load_data = {24'h0, r[7:0]};
      LH:      load_data = {{16{r[15]}}, r[15:0]};
      LHU:     load_data = {16'h0, r[15:0]};
      LW:      load_data = r;
      default: load_data = r;
    endcase
  end

  assign misalign = ((funct3 == LH || funct3 == LHU) && off[0]) ||
                    ((funct3 == LW) && (off != 2'b00));

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage between EXU and WBU: one handshaked word-bus access per op.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_CHECK_EN.
//
// state   | meaning
// IDLE    | ready for a new EXU result
// REQ     | bus request presented, waiting for mem_req_ready
// WAIT    | request accepted, waiting for mem_resp_valid
// DONE    | result held for WBU until out_ready
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDRWIDTH-1:0] EXU_data,
  input  logic [DATAWIDTH-1:0] store_data,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ADDRWIDTH-1:0] mem_req_addr,
  output logic                 mem_req_wen,
  output logic [DATAWIDTH-1:0] mem_req_wdata,
  output logic [3:0]           mem_req_wmask,
  input  logic                 mem_resp_valid,
  input  logic [DATAWIDTH-1:0] mem_resp_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] LSU_data,
  output logic                 out_err
);

  lsu_state_t  state;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        load_q;
  logic        err_q;

  logic [2:0]  sel_f3;
  logic [1:0]  sel_off;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        misalign;
  logic        chk_misalign;
  logic        is_mem;

  assign in_ready = (state == ST_IDLE);
  assign is_mem   = is_load || is_store;

  // Store steering is needed while accepting; load extraction uses the latched op.
  assign sel_f3  = (state == ST_IDLE) ? funct3 : f3_q;
  assign sel_off = (state == ST_IDLE) ? EXU_data[1:0] : off_q;

  lsu_align u_align (
    .funct3     (sel_f3),
    .off        (sel_off),
    .store_data (store_data),
    .rdata      (mem_resp_rdata),
    .wmask      (al_wmask),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misalign   (misalign)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  assign chk_misalign = misalign;
  assign out_err      = err_q;
`else
  logic unused_chk;
  assign chk_misalign = 1'b0;
  assign out_err      = 1'b0;
  assign unused_chk   = misalign | err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      off_q         <= 2'b00;
      f3_q          <= 3'b000;
      load_q        <= 1'b0;
      err_q         <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= 4'b0000;
      out_valid     <= 1'b0;
      LSU_data      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            off_q  <= EXU_data[1:0];
            f3_q   <= funct3;
            load_q <= is_load;
            if (!is_mem) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              LSU_data  <= EXU_data;
            end else if (chk_misalign) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              LSU_data  <= '0;
              err_q     <= 1'b1;
            end else begin
              state         <= ST_REQ;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {EXU_data[ADDRWIDTH-1:2], 2'b00};
              // A load+store encoding is resolved as a load.
              mem_req_wen   <= is_store && !is_load;
              mem_req_wdata <= al_wdata;
              mem_req_wmask <= al_wmask;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            state         <= ST_WAIT;
            mem_req_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            LSU_data  <= load_q ? al_load : '0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed self-checking bench for lsu_stage; expectations follow the
// LSU_MISALIGN_CHECK_EN setting of the build.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] EXU_data;
  logic [31:0] store_data;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] LSU_data;
  logic        out_err;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .EXU_data       (EXU_data),
    .store_data     (store_data),
    .is_load        (is_load),
    .is_store       (is_store),
    .funct3         (funct3),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .LSU_data       (LSU_data),
    .out_err        (out_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, ack the bus immediately if a request appears, return what was seen.
  task automatic run_op(
    input  logic [31:0] addr, input logic [31:0] sd, input logic ld, input logic st,
    input  logic [2:0]  f3,   input logic [31:0] rd,
    output logic g_req, output logic [31:0] g_addr, output logic g_wen,
    output logic [3:0] g_mask, output logic [31:0] g_wdata,
    output logic [31:0] g_data, output logic g_err, output int g_cyc);
    g_req = 1'b0; g_addr = '0; g_wen = 1'b0; g_mask = 4'h0; g_wdata = '0; g_cyc = 0;
    @(negedge clk);
    chk("in_ready_idle", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1; EXU_data = addr; store_data = sd;
    is_load = ld; is_store = st; funct3 = f3;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8 && !out_valid; i++) begin
      g_cyc++;
      if (mem_req_valid) begin
        g_req = 1'b1; g_addr = mem_req_addr; g_wen = mem_req_wen;
        g_mask = mem_req_wmask; g_wdata = mem_req_wdata;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_rdata = rd;
        @(negedge clk);
        mem_resp_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    chk("out_valid_timeout", {31'h0, out_valid}, 32'h1);
    chk("in_ready_done", {31'h0, in_ready}, 32'h0);
    g_data = LSU_data; g_err = out_err;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_clear", {31'h0, out_valid}, 32'h0);
    chk("err_clear", {31'h0, out_err}, 32'h0);
  endtask

  logic        r_req, r_wen, r_err;
  logic [31:0] r_addr, r_wdata, r_data;
  logic [3:0]  r_mask;
  int          r_cyc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; EXU_data = '0; store_data = '0;
    is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0; out_ready = 1'b0;
    #1;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_lsu_data", LSU_data, 32'h0);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk("rst_wmask", {28'h0, mem_req_wmask}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Non-memory pass-through, 1-cycle latency, no bus activity
    run_op(32'h1234, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0,
           r_req, r_addr, r_wen, r_mask, r_wdata, r_data, r_err, r_cyc);
    chk("pt_req", {31'h0, r_req}, 32'h0);
    chk("pt_data", r_data, 32'h1234);
    chk("pt_latency", r_cyc, 32'd0);

    run_op(32'h1003, 32'h0, 1'b1, 1'b0, 3'b000, 32'h80FF_FF00,
           r_req, r_addr, r_wen, r_mask, r_wdata, r_data, r_err, r_cyc);
    chk("lb_req", {31'h0, r_req}, 32'h1);
    chk("lb_addr", r_addr, 32'h1000);
    chk("lb_wen", {31'h0, r_wen}, 32'h0);
    chk("lb_data", r_data, 32'hFFFF_FF80);

    run_op(32'h1003, 32'h0, 1'b1, 1'b0, 3'b100, 32'h80FF_FF00,
           r_req, r_addr, r_wen, r_mask, r_wdata, r_data, r_err, r_cyc);
    chk("lbu_data", r_data, 32'h0000_0080);

    run_op(32'h2002, 32'hABCD_1234, 1'b0, 1'b1, 3'b001, 32'hDEAD_BEEF,
           r_req, r_addr, r_wen, r_mask, r_wdata, r_data, r_err, r_cyc);
    chk("sh_addr", r_addr, 32'h2000);
    chk("sh_wen", {31'h0, r_wen}, 32'h1);
    chk("sh_mask", {28'h0, r_mask}, 32'hC);
    chk("sh_wdata", r_wdata, 32'h1234_0000);
    chk("sh_data", r_data, 32'h0);

    run_op(32'h1002, 32'h0, 1'b1, 1'b0, 3'b001, 32'h8001_1234,
           r_req, r_addr, r_wen, r_mask, r_wdata, r_data, r_err, r_cyc);
    chk("lh_data", r_data, 32'hFFFF_8001);
    run_op(32'h1002, 32'h0, 1'b1, 1'b0, 3'b101, 32'h8001_1234,
           r_req, r_addr, r_wen, r_mask, r_wdata, r_data, r_err, r_cyc);
    chk("lhu_data", r_data, 32'h0000_8001);

    run_op(32'h0001, 32'h0000_00A5, 1'b0, 1'b1, 3'b000, 32'h0,
           r_req, r_addr, r_wen, r_mask, r_wdata, r_data, r_err, r_cyc);
    chk("sb_mask", {28'h0, r_mask}, 32'h2);
    chk("sb_wdata", r_wdata, 32'h0000_A500);

    run_op(32'h0004, 32'hCAFE_F00D, 1'b0, 1'b1, 3'b010, 32'h0,
           r_req, r_addr, r_wen, r_mask, r_wdata, r_data, r_err, r_cyc);
    chk("sw_addr", r_addr, 32'h4);
    chk("sw_mask", {28'h0, r_mask}, 32'hF);
    chk("sw_wdata", r_wdata, 32'hCAFE_F00D);

    // Load+store together behaves as a load
    run_op(32'h0010, 32'h1111_1111, 1'b1, 1'b1, 3'b010, 32'h55AA_55AA,
           r_req, r_addr, r_wen, r_mask, r_wdata, r_data, r_err, r_cyc);
    chk("ldst_wen", {31'h0, r_wen}, 32'h0);
    chk("ldst_data", r_data, 32'h55AA_55AA);

    run_op(32'h3001, 32'h0, 1'b1, 1'b0, 3'b010, 32'h1122_3344,
           r_req, r_addr, r_wen, r_mask, r_wdata, r_data, r_err, r_cyc);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_lw_req", {31'h0, r_req}, 32'h0);
    chk("mis_lw_err", {31'h0, r_err}, 32'h1);
    chk("mis_lw_data", r_data, 32'h0);
`else
    chk("mis_lw_req", {31'h0, r_req}, 32'h1);
    chk("mis_lw_addr", r_addr, 32'h3000);
    chk("mis_lw_mask", {28'h0, r_mask}, 32'hF);
    chk("mis_lw_data", r_data, 32'h0011_2233);
    chk("mis_lw_err", {31'h0, r_err}, 32'h0);
`endif

    run_op(32'h2003, 32'h0000_00EE, 1'b0, 1'b1, 3'b001, 32'h0,
           r_req, r_addr, r_wen, r_mask, r_wdata, r_data, r_err, r_cyc);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_sh_req", {31'h0, r_req}, 32'h0);
    chk("mis_sh_err", {31'h0, r_err}, 32'h1);
`else
    chk("mis_sh_mask", {28'h0, r_mask}, 32'h8);
    chk("mis_sh_wdata", r_wdata, 32'hEE00_0000);
    chk("mis_sh_data", r_data, 32'h0);
`endif

    // Backpressure on request and output, with stray/early responses that must be ignored
    @(negedge clk);
    in_valid = 1'b1; EXU_data = 32'h40; store_data = 32'h0;
    is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
    @(negedge clk);
    in_valid = 1'b0; EXU_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      mem_resp_valid = (i == 1); mem_resp_rdata = 32'h7777_7777;
      chk("bp_req_valid", {31'h0, mem_req_valid}, 32'h1);
      chk("bp_req_addr", mem_req_addr, 32'h40);
      chk("bp_req_wen", {31'h0, mem_req_wen}, 32'h0);
      chk("bp_req_mask", {28'h0, mem_req_wmask}, 32'hF);
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
      @(negedge clk);
    end
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    chk("bp_same_cycle_resp", {31'h0, out_valid}, 32'h0);
    chk("bp_req_dropped", {31'h0, mem_req_valid}, 32'h0);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0BAD_CAFE;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_out_data", LSU_data, 32'h0BAD_CAFE);
      chk("bp_in_ready_done", {31'h0, in_ready}, 32'h0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_out_done", {31'h0, out_valid}, 32'h0);
    chk("bp_in_ready_back", {31'h0, in_ready}, 32'h1);

    // Reset while waiting on a lw, then a late response
    in_valid = 1'b1; EXU_data = 32'h50; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_mid_req", {31'h0, mem_req_valid}, 32'h1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("rst_mid_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_mid_in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("late_resp_out_valid", {31'h0, out_valid}, 32'h0);
    chk("late_resp_in_ready", {31'h0, in_ready}, 32'h1);

    // Reset during REQ drops the request asynchronously
    in_valid = 1'b1; EXU_data = 32'h60;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_req_pre", {31'h0, mem_req_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_async", {31'h0, mem_req_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store unit directly downstream of the EXU.
- Takes the EXU result (EXU_data) as the effective address, or passes it through for non-memory ops.
- Performs one multi-cycle, handshaked word-bus access per instruction.
- Hands the aligned and extended result to write-back with a valid/ready handshake.

Parameters:
DATAWIDTH, 32, data/bus width (only 32 supported)
ADDRWIDTH, 32, address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EXU result valid
in_ready  out  1  LSU can accept
EXU_data  in  32  effective address, or ALU result for non-mem ops
store_data  in  32  rs2 value for stores
is_load  in  1  op is load
is_store  in  1  op is store (is_load && is_store is illegal; treated as load)
funct3  in  3  RISC-V width/sign code
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_req_addr  out  32  word-aligned address {EXU_data[31:2],2'b00}
mem_req_wen  out  1  1 = write
mem_req_wdata  out  32  lane-shifted store data
mem_req_wmask  out  4  byte strobes
mem_resp_valid  in  1  read data / write ack
mem_resp_rdata  in  32  read word
out_valid  out  1  result valid to WBU
out_ready  in  1  WBU accepts
LSU_data  out  32  load result / passthrough / 0 for stores
out_err  out  1  misalignment flag

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All registered outputs 0: mem_req_valid, out_valid, LSU_data, out_err, mem_req_* fields.
  - in_ready=1.
- States: IDLE, REQ, WAIT, DONE. in_ready = (state==IDLE), combinational.
- IDLE, on in_valid:
  - Latch addr, store_data, funct3, op.
  - Non-mem op: go to DONE with LSU_data=EXU_data. Latency 1 cycle.
  - Load or store: go to REQ.
- REQ:
  - mem_req_valid=1. Addr, wen, wdata and wmask are held stable until mem_req_ready.
  - On mem_req_ready: go to WAIT.
  - mem_resp_valid in the same cycle as mem_req_ready is not accepted. The response is taken in WAIT at the earliest.
- WAIT: on mem_resp_valid, go to DONE.
  - Load: LSU_data = extract(rdata).
  - Store: LSU_data = 0.
- DONE: out_valid=1 with data held. On out_ready: go to IDLE.
  - No new input is accepted in the same cycle; minimum 1 idle cycle between ops.
- Lane rules, with off = addr[1:0]:
  - Store mask:
    - sb (000): 4'b0001<<off
    - sh (001): 4'b0011<<off, truncated to 4 bits
    - sw (010) and any other funct3: 4'b1111
  - wdata = store_data << (8*off).
  - Load: r = rdata >> (8*off), then:
    - lb: sign-extend r[7:0]
    - lbu: zero-extend r[7:0]
    - lh: sign-extend r[15:0]
    - lhu: zero-extend r[15:0]
    - lw and funct3 011/110/111: r unchanged
- mem_resp_valid outside WAIT is ignored.
- Reset mid-transaction: FSM returns to IDLE immediately and mem_req_valid drops. A late response after reset is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: a misaligned access (lh/lhu/sh with addr[0]=1; lw/sw with off!=0) issues no bus request. FSM goes IDLE->DONE with LSU_data=0 and out_err=1; out_err clears on leaving DONE.
- Undefined: out_err is tied 0 and misaligned accesses are issued with the truncated mask/shift rules above.

Decomposition:
- Package lsu_pkg:
  - FSM state encoding (2 bits).
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - Byte-mask constants.
- One sub-module lsu_align (combinational):
  - Inputs: funct3, off, store_data, rdata.
  - Outputs: wmask, wdata, load result, misalign flag.
- lsu_stage holds the FSM, request/response handshakes and output registers.

Test Plan:
- Non-mem pass-through: in_valid with is_load=is_store=0, EXU_data=0x1234 -> out_valid next cycle, LSU_data=0x1234, no mem_req_valid.
- lb sign: addr=0x1003, rdata=0x80FF_FF00 -> mem_req_addr=0x1000, wen=0, LSU_data=0xFFFF_FF80. Same with lbu -> 0x0000_0080.
- sh lane: addr=0x2002, store_data=0xABCD_1234 -> wmask=4'b1100, wdata=0x1234_0000, wen=1. After ack, LSU_data=0.
- Backpressure: mem_req_ready held 0 for 3 cycles, then out_ready held 0 for 2 cycles -> request fields stable throughout, out_valid/LSU_data stable, in_ready=0 until handshake.
- Reset mid-WAIT: rst_n=0 while waiting on a lw -> mem_req_valid and out_valid go 0 asynchronously. A late mem_resp_valid after reset is ignored and in_ready=1.
- With LSU_MISALIGN_CHECK_EN: lw at 0x3001 -> no mem_req_valid, out_valid with out_err=1 and LSU_data=0. Without the macro: request issued with wmask 4'b1111 and rdata>>8 returned.
